regfile_sb: RTL
===============

# regfile_sb

Parametrised successor to the 16x16 register file. It adds configurable width and depth, an optional hardwired zero register, and optional write-to-read bypass. It also adds a per-register pending-write scoreboard that tracks up to three outstanding writes per register and reports hazards. It sits between decode (read and issue ports) and writeback (write port) in the pipelined datapath.

## Interface
- DATA_W, 16, register width in bits
- ADDR_W, 4, address width; NREGS = 2**ADDR_W registers
- BYPASS, 0, 1 returns same-cycle write data on a matching read; 0 returns stored data
- ZERO_REG, 0, 1 makes register 0 read as zero and ignore writes and issues

- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- rd_addr1  input  ADDR_W  read port 1 address
- rd_addr2  input  ADDR_W  read port 2 address
- rd_data1  output  DATA_W  read port 1 data, combinational
- rd_data2  output  DATA_W  read port 2 data, combinational
- busy1  output  1  register at rd_addr1 has a pending write
- busy2  output  1  register at rd_addr2 has a pending write
- wr_en  input  1  writeback strobe
- wr_addr  input  ADDR_W  writeback address
- wr_data  input  DATA_W  writeback data
- issue_en  input  1  decode issued an instruction that will write issue_addr
- issue_addr  input  ADDR_W  destination register of the issued instruction
- issue_ovf  output  1  registered one-cycle pulse: issue dropped because the counter was saturated
- wb_unexp  output  1  registered one-cycle pulse: writeback arrived to a register with no pending write

## Operation
- Storage: NREGS x DATA_W flops. Reset clears every register to 0 and every pending counter to 0; issue_ovf = wb_unexp = 0.
- Write: when wr_en is high, regs[wr_addr] <= wr_data at the edge. With ZERO_REG=1 and wr_addr==0, the write is discarded.
- Read: rd_dataN = regs[rd_addrN], with these overrides:
  - ZERO_REG=1 and rd_addrN==0: returns 0.
  - Otherwise, BYPASS=1 and wr_en and wr_addr==rd_addrN: returns wr_data.
- Scoreboard: each register has a 2-bit counter cnt, range 0..3. Per edge, for register r:
  - inc = issue_en && issue_addr==r; dec = wr_en && wr_addr==r.
  - inc && dec: cnt unchanged. If cnt==0, wb_unexp still pulses.
  - inc only: cnt+1 if cnt<3; if cnt==3, cnt holds and issue_ovf pulses next cycle.
  - dec only: cnt-1 if cnt>0; if cnt==0, cnt holds at 0, the write still happens, and wb_unexp pulses next cycle.
  - ZERO_REG=1: counter 0 is constant 0, and r0 events raise no flags.
- busyN = (cnt[rd_addrN] != 0), with these overrides:
  - BYPASS=1, a decrement to r this cycle, and cnt==1: busyN = 0, because the data is being forwarded.
  - ZERO_REG=1 and rd_addrN==0: busyN = 0.
- Both read ports may address the same register, including the register being written.

## Timing
- Write-to-read latency: 1 cycle with BYPASS=0; 0 cycles with BYPASS=1.
- Issue-to-busy latency: 1 cycle. busy is computed from the post-edge counter.
- issue_ovf and wb_unexp are high for exactly one cycle after the offending edge. Each is cleared the following cycle unless a new event occurs.
- Reset asserted at any time: storage, counters and flags clear immediately, without waiting for a clock edge. The first edge after rst deasserts behaves as the first post-reset cycle.
- No back-pressure. The block never stalls; the pipeline uses busyN to stall itself.

## Structure
- Shared package regfile_pkg holds:
  - the default DATA_W/ADDR_W constants;
  - the pending counter width (2) and the saturation constant CNT_MAX=3.
- Sub-module sb_counter: one instance per register. It contains the 2-bit saturating up/down counter, with inputs inc/dec and outputs cnt, ovf and unexp. The top level ORs the per-register ovf and unexp outputs into the registered flags.
- Storage and read muxing stay in the top level, built with generate loops over NREGS.

## Test plan
- Reset, then read all 16 registers -> each reads 0x0000; busy1 = busy2 = 0; both flags 0.
- BYPASS=0: write r5=0xBEEF with rd_addr1=5 in the same cycle -> rd_data1 shows the old 0x0000, then 0xBEEF next cycle. Repeat with BYPASS=1 -> 0xBEEF in the same cycle.
- ZERO_REG=1: write r0=0x1234, issue to r0 -> rd_data1(addr 0) = 0x0000, busy1 = 0, no flags.
- Issue r3 four times, then read -> cnt saturates at 3 and issue_ovf pulses once after the 4th issue. After three writebacks to r3, busy drops; a 4th writeback -> wb_unexp pulses once.
- Same-edge issue and writeback to r7 with cnt=1 -> cnt stays 1, busy stays 1, no flags. Same event with cnt=0 -> wb_unexp pulses and cnt stays 0.
- Assert rst mid-sequence with r2=0xAAAA and cnt[2]=2 -> rd_data = 0 and busy = 0 immediately, before any clock edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
// Defaults match the legacy 16x16 file; counters are 2-bit saturating.
package regfile_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_ADDR_W = 4;
   localparam int CNT_W      = 2;

   typedef logic [CNT_W-1:0] cnt_t;

   localparam cnt_t CNT_MAX  = cnt_t'(3);
   localparam cnt_t CNT_ZERO = cnt_t'(0);

   typedef enum logic [1:0] {
      CNT_IDLE = 2'b00,
      CNT_UP   = 2'b01,
      CNT_DOWN = 2'b10,
      CNT_BOTH = 2'b11
   } cnt_op_e;

   function automatic cnt_op_e cnt_op(input logic inc, input logic dec);
      return cnt_op_e'({dec, inc});
   endfunction

endpackage

// File: rtl/regfile_sb_counter.sv
// Per-register pending-write counter: saturating up/down with one-cycle
// combinational event strobes for overflow and unexpected writeback.
module sb_counter
   import regfile_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic dec,
   output cnt_t cnt,
   output logic ovf,
   output logic unexp
);

   cnt_t cnt_q;
   cnt_t cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      ovf   = 1'b0;
      unexp = 1'b0;
      case (cnt_op(inc, dec))
         CNT_UP: begin
            if (cnt_q == CNT_MAX) ovf = 1'b1;
            else                  cnt_d = cnt_q + cnt_t'(1);
         end
         CNT_DOWN: begin
            if (cnt_q == CNT_ZERO) unexp = 1'b1;
            else                   cnt_d = cnt_q - cnt_t'(1);
         end
         // Issue and writeback cancel, but a writeback with nothing pending is still flagged.
         CNT_BOTH: begin
            if (cnt_q == CNT_ZERO) unexp = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= CNT_ZERO;
      else     cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with optional zero register, write-to-read bypass
// and a per-register pending-write scoreboard reporting busy and hazard flags.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int BYPASS   = 0,
   parameter int ZERO_REG = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] rd_addr1,
   input  logic [ADDR_W-1:0] rd_addr2,
   output logic [DATA_W-1:0] rd_data1,
   output logic [DATA_W-1:0] rd_data2,
   output logic              busy1,
   output logic              busy2,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              issue_en,
   input  logic [ADDR_W-1:0] issue_addr,
   output logic              issue_ovf,
   output logic              wb_unexp
);

   localparam int NREGS = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs_rd [NREGS];
   cnt_t              cnt    [NREGS];
   logic [NREGS-1:0]  wr_hit;
   logic [NREGS-1:0]  issue_hit;
   logic [NREGS-1:0]  ovf_vec;
   logic [NREGS-1:0]  unexp_vec;

   genvar gi;
   generate
      for (gi = 0; gi < NREGS; gi++) begin : g_reg
         // A hardwired zero register sees no writes or issues, so its counter stays at 0.
         localparam bit IS_ZERO = (ZERO_REG != 0) && (gi == 0);

         logic [DATA_W-1:0] reg_q;
         logic [DATA_W-1:0] reg_d;

         assign wr_hit[gi]    = !IS_ZERO && wr_en    && (wr_addr    == ADDR_W'(gi));
         assign issue_hit[gi] = !IS_ZERO && issue_en && (issue_addr == ADDR_W'(gi));

         always_comb begin
            reg_d = reg_q;
            if (wr_hit[gi]) reg_d = wr_data;
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) reg_q <= '0;
            else     reg_q <= reg_d;
         end

         assign regs_rd[gi] = reg_q;

         sb_counter u_cnt (
            .clk   (clk),
            .rst   (rst),
            .inc   (issue_hit[gi]),
            .dec   (wr_hit[gi]),
            .cnt   (cnt[gi]),
            .ovf   (ovf_vec[gi]),
            .unexp (unexp_vec[gi])
         );
      end
   endgenerate

   logic [ADDR_W-1:0] rd_addr [2];
   logic [DATA_W-1:0] rd_data [2];
   logic              busy    [2];

   assign rd_addr[0] = rd_addr1;
   assign rd_addr[1] = rd_addr2;

   generate
      for (gi = 0; gi < 2; gi++) begin : g_port
         logic fwd;
         logic is_zero;

         assign fwd     = (BYPASS != 0) && wr_en && (wr_addr == rd_addr[gi]);
         assign is_zero = (ZERO_REG != 0) && (rd_addr[gi] == '0);

         always_comb begin
            rd_data[gi] = regs_rd[rd_addr[gi]];
            busy[gi]    = (cnt[rd_addr[gi]] != CNT_ZERO);
            // Last pending write is being forwarded now, so the consumer need not stall.
            if (fwd) begin
               rd_data[gi] = wr_data;
               if (cnt[rd_addr[gi]] == cnt_t'(1)) busy[gi] = 1'b0;
            end
            if (is_zero) begin
               rd_data[gi] = '0;
               busy[gi]    = 1'b0;
            end
         end
      end
   endgenerate

   assign rd_data1 = rd_data[0];
   assign rd_data2 = rd_data[1];
   assign busy1    = busy[0];
   assign busy2    = busy[1];

   logic issue_ovf_q, issue_ovf_d;
   logic wb_unexp_q,  wb_unexp_d;

   always_comb begin
      issue_ovf_d = |ovf_vec;
      wb_unexp_d  = |unexp_vec;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         issue_ovf_q <= 1'b0;
         wb_unexp_q  <= 1'b0;
      end else begin
         issue_ovf_q <= issue_ovf_d;
         wb_unexp_q  <= wb_unexp_d;
      end
   end

   assign issue_ovf = issue_ovf_q;
   assign wb_unexp  = wb_unexp_q;

endmodule
